// File: rtl/lcd_controller.sv
// Sequencer for a 4x16 HD44780-style display: power-on init, then whole-screen refresh.
// Every bus transfer runs SETUP -> PULSE -> HOLD -> WAIT; all pin outputs are registered.

module lcd_controller #(
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 4,
    parameter int CMD_WAIT  = 40,
    parameter int CLR_WAIT  = 1600
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic [3:0][15:0][7:0] frame,
    input  logic                  frame_valid,
    output logic                  frame_ready,
    output logic                  busy,
    output logic                  lcd_enable_l,
    output logic                  lcd_rs,
    output logic                  lcd_rw,
    output logic [7:0]            lcd_bus
);

    localparam int MAX_A   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int MAX_B   = (CMD_WAIT > CLR_WAIT) ? CMD_WAIT : CLR_WAIT;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT - 1);
    localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_WAIT - 1);

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        XFER_ADDR,
        XFER_DATA
    } state_t;

    // PH_NONE marks "no transfer in flight": the next edge either launches one or waits for a frame.
    typedef enum logic [2:0] {
        PH_NONE,
        PH_SETUP,
        PH_PULSE,
        PH_HOLD,
        PH_WAIT
    } phase_t;

    state_t                  state, state_nxt;
    phase_t                  phase, phase_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [CNT_W-1:0]        wait_last;
    logic [1:0]              row, row_nxt;
    logic [3:0]              col, col_nxt;
    logic [1:0]              init_idx, idx_nxt;
    logic [3:0][15:0][7:0]   shadow;
    logic                    en_nxt;
    logic                    ready_nxt;
    logic                    busy_nxt;
    logic                    capture;
    logic                    launch;
    logic [7:0]              launch_byte;

    function automatic logic [7:0] row_base(input logic [1:0] r);
        logic [7:0] b;
        case (r)
            2'd0:    b = 8'h00;
            2'd1:    b = 8'h40;
            2'd2:    b = 8'h10;
            default: b = 8'h50;
        endcase
        return b;
    endfunction

    assign lcd_rw = 1'b0;

    // Only the clear command gets the long settle time.
    assign wait_last = (state == INIT && init_idx == 2'd3) ? CLR_LAST : CMD_LAST;

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        cnt_nxt   = cnt;
        row_nxt   = row;
        col_nxt   = col;
        idx_nxt   = init_idx;
        en_nxt    = lcd_enable_l;
        ready_nxt = frame_ready;
        busy_nxt  = busy;
        capture   = 1'b0;
        launch    = 1'b0;

        case (phase)
            PH_NONE: begin
                if (state == IDLE) begin
                    if (frame_valid && frame_ready) begin
                        capture   = 1'b1;
                        state_nxt = XFER_ADDR;
                        row_nxt   = 2'd0;
                        col_nxt   = 4'd0;
                        ready_nxt = 1'b0;
                        busy_nxt  = 1'b1;
                    end
                end else begin
                    launch = 1'b1;
                end
            end
            PH_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    phase_nxt = PH_PULSE;
                    cnt_nxt   = '0;
                    en_nxt    = 1'b0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PH_PULSE: begin
                if (cnt == EN_LAST) begin
                    phase_nxt = PH_HOLD;
                    cnt_nxt   = '0;
                    en_nxt    = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PH_HOLD: begin
                phase_nxt = PH_WAIT;
                cnt_nxt   = '0;
            end
            PH_WAIT: begin
                if (cnt == wait_last) begin
                    launch = 1'b1;
                    case (state)
                        INIT: begin
                            if (init_idx == 2'd3) begin
                                launch    = 1'b0;
                                state_nxt = IDLE;
                                phase_nxt = PH_NONE;
                                cnt_nxt   = '0;
                                ready_nxt = 1'b1;
                                busy_nxt  = 1'b0;
                            end else begin
                                idx_nxt = init_idx + 1'b1;
                            end
                        end
                        XFER_ADDR: begin
                            state_nxt = XFER_DATA;
                            col_nxt   = 4'd0;
                        end
                        XFER_DATA: begin
                            // Explicit last-cell compare ends the frame; counter wrap is never relied on.
                            if (row == 2'd3 && col == 4'd15) begin
                                launch    = 1'b0;
                                state_nxt = IDLE;
                                phase_nxt = PH_NONE;
                                cnt_nxt   = '0;
                                ready_nxt = 1'b1;
                                busy_nxt  = 1'b0;
                            end else if (col == 4'd15) begin
                                state_nxt = XFER_ADDR;
                                row_nxt   = row + 1'b1;
                                col_nxt   = 4'd0;
                            end else begin
                                col_nxt = col + 1'b1;
                            end
                        end
                        default: launch = 1'b0;
                    endcase
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: phase_nxt = PH_NONE;
        endcase

        if (launch) begin
            phase_nxt = PH_SETUP;
            cnt_nxt   = '0;
            en_nxt    = 1'b1;
        end
    end

    always_comb begin
        launch_byte = 8'h00;
        case (state_nxt)
            INIT: begin
                case (idx_nxt)
                    2'd0:    launch_byte = 8'h38;
                    2'd1:    launch_byte = 8'h0C;
                    2'd2:    launch_byte = 8'h06;
                    default: launch_byte = 8'h01;
                endcase
            end
            XFER_ADDR: launch_byte = 8'h80 | row_base(row_nxt);
            XFER_DATA: launch_byte = shadow[row_nxt][col_nxt];
            default:   launch_byte = 8'h00;
        endcase
    end

    // RS and bus only ever load at SETUP start, so they stay frozen through PULSE and HOLD.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state        <= INIT;
            phase        <= PH_NONE;
            cnt          <= '0;
            row          <= 2'd0;
            col          <= 4'd0;
            init_idx     <= 2'd0;
            shadow       <= '0;
            lcd_enable_l <= 1'b1;
            lcd_rs       <= 1'b0;
            lcd_bus      <= 8'h00;
            frame_ready  <= 1'b0;
            busy         <= 1'b1;
        end else begin
            state        <= state_nxt;
            phase        <= phase_nxt;
            cnt          <= cnt_nxt;
            row          <= row_nxt;
            col          <= col_nxt;
            init_idx     <= idx_nxt;
            lcd_enable_l <= en_nxt;
            frame_ready  <= ready_nxt;
            busy         <= busy_nxt;
            if (capture) begin
                shadow <= frame;
            end
            if (launch) begin
                lcd_rs  <= (state_nxt == XFER_DATA);
                lcd_bus <= launch_byte;
            end
        end
    end

endmodule
